// File: rtl/cpu_pkg.sv
// Shared opcode constants, issue-FSM state encoding and default datapath width
// for the ALU issue/capture stage.
package cpu_pkg;

   localparam int unsigned DEFAULT_WIDTH = 32;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SLT = 3'd5;
   localparam logic [2:0] OP_NOR = 3'd6;
   localparam logic [2:0] OP_MUL = 3'd7;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StMul  = 2'd1,
      StExec = 2'd2,
      StResp = 2'd3
   } issue_state_e;

endpackage

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle for WIDTH cycles,
// product truncated to WIDTH bits and held until the next start.
module shift_add_multiplier
   import cpu_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_done,
   output logic [WIDTH-1:0] o_product
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   logic             r_busy;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] r_acc;

   logic             w_last;
   logic [WIDTH-1:0] w_addend;

   always_comb begin
      w_last   = r_busy & (r_cnt == LAST_CNT);
      w_addend = r_mplier[0] ? r_mcand : '0;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_busy   <= 1'b0;
         r_cnt    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
      end else if (i_start) begin
         r_busy   <= 1'b1;
         r_cnt    <= '0;
         r_mcand  <= i_a;
         r_mplier <= i_b;
         r_acc    <= '0;
      end else if (r_busy) begin
         // Accumulator wraps naturally, giving the product modulo 2^WIDTH.
         r_acc    <= r_acc + w_addend;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         if (w_last) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_done    = w_last;
   assign o_product = r_acc;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/capture stage for the ALU result mux bank: accepts one op, drives the mux select,
// runs the multiplier for MUL, captures the mux output and presents it on a response port.
module alu_issue_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_req_valid,
   output logic             o_req_ready,
   input  logic [2:0]       i_req_op,
   input  logic [WIDTH-1:0] i_req_a,
   input  logic [WIDTH-1:0] i_req_b,
   output logic [WIDTH-1:0] o_op_a,
   output logic [WIDTH-1:0] o_op_b,
   output logic [2:0]       o_sel,
   output logic [WIDTH-1:0] o_mul_product,
   input  logic [WIDTH-1:0] i_mux_result,
   output logic             o_rsp_valid,
   input  logic             i_rsp_ready,
   output logic [WIDTH-1:0] o_rsp_data,
   output logic             o_rsp_zero
);

   issue_state_e r_state;
   issue_state_e w_state_d;

   logic [WIDTH-1:0] r_op_a;
   logic [WIDTH-1:0] r_op_b;
   logic [2:0]       r_sel;
   logic [WIDTH-1:0] r_rsp_data;
   logic             r_rsp_zero;

   logic w_req_hs;
   logic w_mul_start;
   logic w_mul_done;
   logic w_capture;

   always_comb begin
      w_state_d   = r_state;
      o_req_ready = 1'b0;
      o_rsp_valid = 1'b0;
      w_capture   = 1'b0;
      unique case (r_state)
         StIdle: begin
            o_req_ready = 1'b1;
            if (i_req_valid) begin
               w_state_d = (i_req_op == OP_MUL) ? StMul : StExec;
            end
         end
         StMul: begin
            if (w_mul_done) begin
               w_state_d = StExec;
            end
         end
         StExec: begin
            w_capture = 1'b1;
            w_state_d = StResp;
         end
         StResp: begin
            o_rsp_valid = 1'b1;
            if (i_rsp_ready) begin
               w_state_d = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   assign w_req_hs    = i_req_valid & o_req_ready;
   assign w_mul_start = w_req_hs & (i_req_op == OP_MUL);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   // Operands and select stay put until the next accepted request.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_op_a <= '0;
         r_op_b <= '0;
         r_sel  <= OP_ADD;
      end else if (w_req_hs) begin
         r_op_a <= i_req_a;
         r_op_b <= i_req_b;
         r_sel  <= i_req_op;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_rsp_data <= '0;
         r_rsp_zero <= 1'b1;
      end else if (w_capture) begin
         r_rsp_data <= i_mux_result;
         r_rsp_zero <= (i_mux_result == '0);
      end
   end

   shift_add_multiplier #(
      .WIDTH (WIDTH)
   ) u_mul (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_start   (w_mul_start),
      .i_a       (i_req_a),
      .i_b       (i_req_b),
      .o_done    (w_mul_done),
      .o_product (o_mul_product)
   );

   assign o_op_a     = r_op_a;
   assign o_op_b     = r_op_b;
   assign o_sel      = r_sel;
   assign o_rsp_data = r_rsp_data;
   assign o_rsp_zero = r_rsp_zero;

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential issue/capture stage in front of the ALU result mux bank. Accepts one operation per request via valid/ready, registers operands, drives the 3-bit result-mux select, runs an iterative shift-add multiply for opcode 7, then captures the selected mux output into a result register. The result is presented downstream on a valid/ready response port.

## Interface
- `WIDTH`, default 32: datapath width; must be ≥ 2.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_op` in 3: opcode.
- `req_a` in WIDTH: operand A.
- `req_b` in WIDTH: operand B.
- `op_a` out WIDTH: registered operand A, to the ALU function units.
- `op_b` out WIDTH: registered operand B, to the ALU function units.
- `sel` out 3: result-mux select.
- `mul_product` out WIDTH: multiplier result, wired to mux input 7.
- `mux_result` in WIDTH: output of the result mux bank.
- `rsp_valid` out 1: result valid.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_data` out WIDTH: captured result.
- `rsp_zero` out 1: high when `rsp_data` is 0.

## Operation
- States:
  - IDLE: `req_ready` = 1.
  - MUL: multiply iteration.
  - EXEC: `sel` valid; `mux_result` captured at the end of the cycle.
  - RESP: `rsp_valid` = 1.
- Transitions:
  - IDLE→EXEC on handshake with `req_op` ≠ 7.
  - IDLE→MUL on handshake with `req_op` = 7.
  - MUL→EXEC after WIDTH iterations.
  - EXEC→RESP unconditionally.
  - RESP→IDLE on `rsp_ready`.
- Request handshake:
  - On `req_valid & req_ready`, latch `req_a`, `req_b` into `op_a`, `op_b` and latch `req_op` into `sel`.
  - `req_ready` is 0 in every state except IDLE. There is no accept-while-responding.
- Opcode map (the mux bank wires these inputs): 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 NOR, 7 MUL.
  - This block does not interpret opcodes 0–6. It only selects them.
- MUL:
  - Accumulator cleared on entry.
  - Multiplicand = `op_a`, shifted left 1 bit per cycle.
  - Multiplier = `op_b`, shifted right 1 bit per cycle.
  - Accumulator += multiplicand when the multiplier LSB = 1.
  - A 0..WIDTH-1 counter ends the state.
  - `mul_product` = accumulator, modulo 2^WIDTH, unsigned. It is held stable from MUL exit until the next MUL entry.
- RESP:
  - `rsp_data` and `rsp_zero` are held stable while `rsp_valid` = 1 and `rsp_ready` = 0.
  - `rsp_valid` drops the cycle after the handshake.
- `sel` holds its last value outside EXEC/MUL.
  - `op_a` and `op_b` hold until the next accepted request.
- Reset values (asynchronous on `reset_n` = 0, including mid-MUL or mid-RESP):
  - State = IDLE.
  - `req_ready` = 1 after reset release.
  - `rsp_valid` = 0, `rsp_data` = 0, `rsp_zero` = 1.
  - `sel` = 0, `op_a` = `op_b` = 0, `mul_product` = 0, counter = 0.
  - Any in-flight operation is dropped with no response.

## Timing
- Non-MUL request, accepted at edge N:
  - EXEC during cycle N..N+1; `mux_result` sampled at edge N+1.
  - `rsp_valid` high from edge N+1.
  - Earliest response handshake at edge N+2.
  - `req_ready` high again after edge N+2 at the earliest.
- MUL request, accepted at edge N:
  - MUL occupies WIDTH cycles; EXEC follows; `rsp_valid` high from edge N+WIDTH+1.
- The `mux_result` path is combinational from `sel`, `op_a`, `op_b` within one cycle. `sel`, `op_a` and `op_b` are stable for the whole EXEC cycle.
- Back-to-back throughput: one op per 3 cycles (non-MUL) when `rsp_ready` is tied high.

## Structure
- Shared package `cpu_pkg`:
  - Opcode constants `OP_ADD` … `OP_MUL` (3-bit).
  - State encoding for IDLE/MUL/EXEC/RESP (2-bit).
  - Default WIDTH.
- Sub-module `shift_add_multiplier` holds the accumulator, shifters and counter.
  - Ports: `clk`, `reset_n`, `start`, `a`, `b`, `done`, `product`.
  - Counter width = $clog2(WIDTH).
- FSM, operand registers, `sel` register and response register stay in `alu_issue_ctrl`.

## Test plan
- Reset release:
  - All outputs at their reset values.
  - `req_ready` = 1.
  - `rsp_valid` = 0 for 5 idle cycles.
- op = 2, a = 0xF0F0_F0F0, b = 0x0FF0_0FF0, bench mux model, `rsp_ready` tied high:
  - `sel` = 2 during EXEC.
  - `rsp_data` = 0x00F0_00F0 at edge N+1.
  - `rsp_zero` = 0.
- op = 7, a = 0x0001_0003, b = 0x0000_0005:
  - `rsp_valid` high exactly at edge N+33.
  - `rsp_data` = 0x0005_000F.
- op = 7, a = 0xFFFF_FFFF, b = 2:
  - `rsp_data` = 0xFFFF_FFFE (wrap-around).
  - Then op = 1, a = b = 7 → `rsp_data` = 0, `rsp_zero` = 1.
- Backpressure: hold `rsp_ready` = 0 for 10 cycles while `req_valid` stays high with a new op:
  - `rsp_data` stable.
  - `req_ready` = 0 throughout.
  - The new op is accepted only after the response handshake.
- Assert `reset_n` = 0 asynchronously at MUL iteration 12:
  - Immediate return to IDLE.
  - No response issued.
  - A following op = 0, a = 3, b = 4 returns 7.
